// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word reads over a ready handshake
// and hands each fetched word to the decoder with a one-cycle load pulse.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] inst_data,
  output logic        inst_en,
  output logic [15:0] pc,
  output logic [15:0] pc_next,
  output logic        fetch_busy,
  output logic        fetch_fault
);

  // state   | meaning
  // S_IDLE  | no read outstanding; starts a fetch when fetch_req is high
  // S_REQ   | mem_rd held high, waiting for mem_ready or timeout
  // S_FAULT | misaligned redirect or timeout; only an even redirect leaves
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q;
  logic [15:0] fetch_pc_q;
  logic [15:0] inst_data_q;
  logic [15:0] pc_q;
  logic [15:0] pc_next_q;
  logic        mem_rd_q;
  logic        inst_en_q;
  logic        busy_q;
  logic        fault_q;
  logic [7:0]  wait_q;
  logic [15:0] fetch_pc_inc_d;

  assign fetch_pc_inc_d = fetch_pc_q + 16'd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      inst_data_q <= 16'h0000;
      pc_q        <= RESET_PC;
      pc_next_q   <= RESET_PC + 16'd2;
      mem_rd_q    <= 1'b0;
      inst_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      wait_q      <= 8'd0;
    end else begin
      inst_en_q <= 1'b0;
      // Redirect wins over any same-cycle mem_ready; that returning word is dropped.
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        mem_rd_q   <= 1'b0;
        busy_q     <= 1'b0;
        if (redirect_pc[0]) begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end else begin
          state_q <= S_IDLE;
          fault_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fetch_req) begin
              state_q  <= S_REQ;
              mem_rd_q <= 1'b1;
              busy_q   <= 1'b1;
              wait_q   <= 8'd0;
            end
          end
          S_REQ: begin
            if (mem_ready) begin
              inst_data_q <= mem_rdata;
              inst_en_q   <= 1'b1;
              pc_q        <= fetch_pc_q;
              pc_next_q   <= fetch_pc_inc_d;
              fetch_pc_q  <= fetch_pc_inc_d;
              state_q     <= S_IDLE;
              mem_rd_q    <= 1'b0;
              busy_q      <= 1'b0;
            end else if (wait_q == WAIT_LAST) begin
              wait_q   <= wait_q + 8'd1;
              state_q  <= S_FAULT;
              fault_q  <= 1'b1;
              mem_rd_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              wait_q <= wait_q + 8'd1;
            end
          end
          S_FAULT: begin
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr    = fetch_pc_q;
  assign mem_rd      = mem_rd_q;
  assign inst_data   = inst_data_q;
  assign inst_en     = inst_en_q;
  assign pc          = pc_q;
  assign pc_next     = pc_next_q;
  assign fetch_busy  = busy_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] inst_data;
  logic        inst_en;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        fetch_busy;
  logic        fetch_fault;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .inst_data(inst_data),
    .inst_en(inst_en), .pc(pc), .pc_next(pc_next), .fetch_busy(fetch_busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a read is outstanding or not, the core is faulted or not.
  logic        m_outstanding, m_faulted, m_new;
  int          m_waited;
  logic [15:0] m_fpc, m_word, m_pc, m_link;

  task automatic model_reset();
    m_outstanding = 1'b0;
    m_faulted     = 1'b0;
    m_new         = 1'b0;
    m_waited      = 0;
    m_fpc         = RESET_PC;
    m_word        = 16'h0000;
    m_pc          = RESET_PC;
    m_link        = RESET_PC + 16'd2;
  endtask

  task automatic model_step(input logic req, input logic redir, input logic [15:0] rpc,
                            input logic rdy, input logic [15:0] rdat);
    m_new = 1'b0;
    if (redir) begin
      m_fpc = rpc;
      m_outstanding = 1'b0;
      m_faulted = rpc[0];
    end else if (m_faulted) begin
      m_outstanding = 1'b0;
    end else if (!m_outstanding) begin
      if (req) begin
        m_outstanding = 1'b1;
        m_waited = 0;
      end
    end else if (rdy) begin
      m_new = 1'b1;
      m_word = rdat;
      m_pc = m_fpc;
      m_link = m_fpc + 16'd2;
      m_fpc = m_fpc + 16'd2;
      m_outstanding = 1'b0;
    end else begin
      m_waited++;
      if (m_waited >= MAX_WAIT) begin
        m_outstanding = 1'b0;
        m_faulted = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_addr", mem_addr, m_fpc);
    chk("mem_rd", {15'd0, mem_rd}, {15'd0, m_outstanding});
    chk("fetch_busy", {15'd0, fetch_busy}, {15'd0, m_outstanding});
    chk("fetch_fault", {15'd0, fetch_fault}, {15'd0, m_faulted});
    chk("inst_en", {15'd0, inst_en}, {15'd0, m_new});
    chk("inst_data", inst_data, m_word);
    chk("pc", pc, m_pc);
    chk("pc_next", pc_next, m_link);
  endtask

  task automatic cycle(input logic req, input logic redir, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] rdat);
    fetch_req   = req;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ready   = rdy;
    mem_rdata   = rdat;
    @(posedge clk);
    model_step(req, redir, rpc, rdy, rdat);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, RESET_PC);
    chk({tag, "_mem_rd"}, {15'd0, mem_rd}, 16'd0);
    chk({tag, "_inst_data"}, inst_data, 16'h0000);
    chk({tag, "_inst_en"}, {15'd0, inst_en}, 16'd0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_pc_next"}, pc_next, RESET_PC + 16'd2);
    chk({tag, "_busy"}, {15'd0, fetch_busy}, 16'd0);
    chk({tag, "_fault"}, {15'd0, fetch_fault}, 16'd0);
  endtask

  logic [15:0] words [3] = '{16'h00A1, 16'h00A2, 16'h00A3};
  int en_cyc [3];
  int cyc_cnt;
  int rd_cnt, en_cnt;
  logic [15:0] held;
  logic [15:0] rpc_r;

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    reset = 1'b1;

    // Single fetch at zero wait.
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t1_addr", mem_addr, 16'h0000);
    chk("t1_rd", {15'd0, mem_rd}, 16'd1);
    cycle(0, 0, 16'h0, 1, 16'h4C0A);
    chk("t1_en", {15'd0, inst_en}, 16'd1);
    chk("t1_data", inst_data, 16'h4C0A);
    chk("t1_pc", pc, 16'h0000);
    chk("t1_pcn", pc_next, 16'h0002);
    chk("t1_rd_drop", {15'd0, mem_rd}, 16'd0);
    cycle(0, 0, 16'h0, 0, 16'h0);
    chk("t1_en_pulse", {15'd0, inst_en}, 16'd0);

    // Held fetch_req with three wait cycles per word.
    cycle(0, 1, 16'h0000, 0, 16'h0);
    cyc_cnt = 0;
    for (int w = 0; w < 3; w++) begin
      cycle(1, 0, 16'h0, 0, 16'h0);
      cyc_cnt++;
      chk("t2_addr", mem_addr, 16'(2 * w));
      for (int k = 0; k < 3; k++) begin
        cycle(1, 0, 16'h0, 0, 16'h0);
        cyc_cnt++;
      end
      cycle(w < 2 ? 1'b1 : 1'b0, 0, 16'h0, 1, words[w]);
      cyc_cnt++;
      chk("t2_en", {15'd0, inst_en}, 16'd1);
      chk("t2_data", inst_data, words[w]);
      en_cyc[w] = cyc_cnt;
    end
    chk("t2_gap1", 16'(en_cyc[1] - en_cyc[0]), 16'd5);
    chk("t2_gap2", 16'(en_cyc[2] - en_cyc[1]), 16'd5);

    // Redirect colliding with mem_ready drops the returned word.
    cycle(0, 1, 16'h0004, 0, 16'h0);
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t3_addr", mem_addr, 16'h0004);
    held = inst_data;
    cycle(0, 0, 16'h0, 0, 16'h0);
    cycle(0, 1, 16'h0100, 1, 16'hDEAD);
    chk("t3_no_en", {15'd0, inst_en}, 16'd0);
    chk("t3_data_held", inst_data, held);
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t3_addr2", mem_addr, 16'h0100);
    cycle(0, 0, 16'h0, 1, 16'h5555);
    chk("t3_pc", pc, 16'h0100);

    // Misaligned redirect faults; even redirect recovers.
    cycle(1, 1, 16'h0101, 0, 16'h0);
    chk("t4_fault", {15'd0, fetch_fault}, 16'd1);
    repeat (3) cycle(1, 0, 16'h0, 1, 16'h1111);
    chk("t4_rd_ign", {15'd0, mem_rd}, 16'd0);
    cycle(0, 1, 16'h0200, 0, 16'h0);
    chk("t4_clear", {15'd0, fetch_fault}, 16'd0);
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t4_addr", mem_addr, 16'h0200);
    cycle(0, 0, 16'h0, 1, 16'h7777);
    chk("t4_pc", pc, 16'h0200);

    // Timeout: memory never answers.
    rd_cnt = 0;
    en_cnt = 0;
    cycle(1, 0, 16'h0, 0, 16'h0);
    rd_cnt += int'(mem_rd);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 16'h0, 0, 16'h0);
      rd_cnt += int'(mem_rd);
      en_cnt += int'(inst_en);
    end
    chk("t5_rd_cycles", 16'(rd_cnt), 16'(MAX_WAIT));
    chk("t5_no_en", 16'(en_cnt), 16'd0);
    chk("t5_fault", {15'd0, fetch_fault}, 16'd1);

    // Address wrap-around, then asynchronous reset mid-fetch.
    cycle(0, 1, 16'hFFFE, 0, 16'h0);
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t6_addr0", mem_addr, 16'hFFFE);
    cycle(0, 0, 16'h0, 1, 16'h1234);
    chk("t6_pc", pc, 16'hFFFE);
    chk("t6_pcn", pc_next, 16'h0000);
    cycle(1, 0, 16'h0, 0, 16'h0);
    chk("t6_addr1", mem_addr, 16'h0000);
    chk("t6_rd", {15'd0, mem_rd}, 16'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_values("async");
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    @(posedge clk);
    #1;
    check_reset_values("in_reset");
    #2;
    reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rpc_r = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rpc_r[0] = 1'b0;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc_r,
            $urandom_range(0, 2) == 0, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer end of the decoder's instruction interface.
- Holds the fetch PC and issues word reads to instruction memory over a ready-handshake port.
- Presents each fetched word on inst_data with a one-cycle inst_en pulse that drives the decoder's load enable.
- Takes PC redirects from branch/PC-write logic, aborts in-flight fetches, and flags misaligned or timed-out fetches.

Parameters:
- RESET_PC, 16'h0000, fetch PC value after reset. Must be even.
- MAX_WAIT, 8, number of cycles mem_rd may stay high without mem_ready before a timeout fault. Range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  level; core requests the next instruction.
- redirect  in  1  one-cycle pulse; load redirect_pc as the new fetch PC.
- redirect_pc  in  16  new byte address for the fetch PC.
- mem_addr  out  16  instruction memory byte address.
- mem_rd  out  1  read request; held high until mem_ready or abort.
- mem_ready  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  16  instruction word from memory.
- inst_data  out  16  last fetched instruction word; held between fetches.
- inst_en  out  1  one-cycle pulse; inst_data is new this cycle.
- pc  out  16  byte address of the word on inst_data.
- pc_next  out  16  pc + 2 (link value), modulo 2^16.
- fetch_busy  out  1  high in REQ state.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, mem_addr=RESET_PC, mem_rd=0, inst_data=0, inst_en=0, pc=RESET_PC, pc_next=RESET_PC+2, fetch_busy=0, fetch_fault=0, wait counter=0. Reset asserted mid-fetch drops mem_rd immediately; a returning mem_ready is ignored.
- All outputs are registered. mem_addr always equals fetch_pc.
- States: IDLE, REQ, FAULT.
- IDLE:
  - fetch_req=1 and no redirect: next state REQ; mem_rd=1 from the next cycle; wait counter cleared.
- REQ:
  - mem_rd=1; wait counter increments each cycle mem_ready=0.
  - mem_ready=1: next cycle inst_data=mem_rdata, inst_en=1, pc=fetch_pc, pc_next=fetch_pc+2. fetch_pc advances by 2. Return to IDLE; mem_rd=0.
  - One instruction is fetched per IDLE->REQ pass. A held fetch_req yields back-to-back fetches every 2 cycles at zero memory wait.
- Latency: fetch_req sampled high in IDLE at edge N gives mem_rd high in cycle N+1. If mem_ready is high in that cycle, inst_en is high in cycle N+2.
- inst_en is never high for two consecutive cycles.
- Redirect has priority over everything except reset. It applies in IDLE and REQ:
  - fetch_pc <= redirect_pc; state <= IDLE; mem_rd <= 0.
  - Any mem_ready in the same cycle is discarded: no inst_en, inst_data and pc unchanged.
  - redirect_pc[0]=1 (misaligned): state <= FAULT, fetch_pc still loaded.
- Timeout: in REQ, if the wait counter reaches MAX_WAIT with mem_ready=0, next state FAULT and mem_rd=0.
- FAULT:
  - fetch_fault=1; fetch_req ignored; mem_rd=0.
  - Exits only on redirect with even redirect_pc: state <= IDLE, fetch_fault <= 0.
  - A redirect with odd redirect_pc stays in FAULT and updates fetch_pc.
- Wrap-around: fetch_pc 16'hFFFE advances to 16'h0000; pc_next for pc=16'hFFFE is 16'h0000. No fault.
- fetch_req and redirect in the same cycle: the redirect wins and no fetch starts that cycle. fetch_req still high in the next IDLE cycle fetches from redirect_pc.
- fetch_busy = (state==REQ).

Test Plan:
- Reset then a fetch_req pulse, with memory returning 16'h4C0A at zero wait: mem_addr=0000 and mem_rd high 1 cycle; inst_en pulse 2 cycles after the request; inst_data=4C0A, pc=0000, pc_next=0002.
- fetch_req held high, memory with 3 wait cycles, words A1,A2,A3: mem_addr sequence 0000, 0002, 0004; three inst_en pulses spaced 5 cycles apart; inst_data matches in order.
- Redirect to 16'h0100 asserted in the same cycle as mem_ready during a fetch at 0004: no inst_en, inst_data unchanged. The next fetch reads 0100, and pc=0100 on delivery.
- Redirect to 16'h0101: fetch_fault=1 and fetch_req is ignored. A later redirect to 0200 clears the fault, and the next fetch reads 0200.
- MAX_WAIT=8 with mem_ready never asserted: mem_rd high exactly 8 cycles, then drops; fetch_fault=1 with no inst_en.
- Redirect to FFFE then two fetches: mem_addr FFFE then 0000; pc_next=0000 on the first delivery. Asserting reset low while mem_rd is high drops mem_rd asynchronously, and all outputs return to their reset values.
